// File: rtl/sdram_scheduler.sv
// sdram_scheduler: shares the single-word SDRAM controller command port
// between a write requester and a read requester. It also runs the power-up
// init sequence and inserts periodic auto-refresh. Each command owns a fixed
// time slot, and all outputs are registered.
module sdram_scheduler #(
  parameter int          ASIZE      = 25,
  parameter int          DSIZE      = 16,
  parameter int          INIT_WAIT  = 20000,
  parameter int          REF_PERIOD = 1560,
  parameter int          CMD_SLOT   = 8,
  parameter int          REF_SLOT   = 10,
  parameter int          RD_LAT     = 6,
  parameter logic [12:0] MODE_WORD  = 13'h020
) (
  input  logic               clk,
  input  logic               reset,
  output logic               init_done,
  input  logic               wr_req,
  input  logic [ASIZE-1:0]   wr_addr,
  input  logic [DSIZE-1:0]   wr_data,
  input  logic [DSIZE/8-1:0] wr_dm,
  output logic               wr_gnt,
  input  logic               rd_req,
  input  logic [ASIZE-1:0]   rd_addr,
  output logic               rd_gnt,
  output logic [DSIZE-1:0]   rd_data,
  output logic               rd_valid,
  output logic [2:0]         sdr_cmd,
  output logic [ASIZE-1:0]   sdr_addr,
  output logic [DSIZE-1:0]   sdr_datain,
  output logic [DSIZE/8-1:0] sdr_dm,
  input  logic [DSIZE-1:0]   sdr_dataout
);

  localparam logic [2:0] CMD_NOP       = 3'b000;
  localparam logic [2:0] CMD_READA     = 3'b001;
  localparam logic [2:0] CMD_WRITEA    = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b011;
  localparam logic [2:0] CMD_PRECHARGE = 3'b100;
  localparam logic [2:0] CMD_LOAD_MODE = 3'b101;

  // One counter serves the init wait and every slot, so size it for the longest.
  localparam int CNT_MAX = (INIT_WAIT > REF_SLOT) ?
                           ((INIT_WAIT > CMD_SLOT) ? INIT_WAIT : CMD_SLOT) :
                           ((REF_SLOT > CMD_SLOT) ? REF_SLOT : CMD_SLOT);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int REF_W = $clog2(REF_PERIOD + 1);
  localparam int LAT_W = (RD_LAT < 3) ? 2 : $clog2(RD_LAT + 1);

  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(INIT_WAIT);
  localparam logic [CNT_W-1:0] REF_END  = CNT_W'(REF_SLOT - 1);
  localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(CMD_SLOT - 1);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REF_PERIOD);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RD_LAT);

  // PRECHARGE with A10 set closes all banks.
  localparam logic [ASIZE-1:0] PRE_ALL_ADDR = ASIZE'(11'h400);
  localparam logic [ASIZE-1:0] MODE_ADDR    = ASIZE'(MODE_WORD);

  typedef enum logic [2:0] {
    S_WAIT,
    S_PRE,
    S_REF1,
    S_REF2,
    S_LMR,
    S_IDLE,
    S_SLOT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             slot_ref;
  logic [REF_W-1:0] ref_cnt;
  logic             ref_pending;
  logic             prefer_rd;
  logic             grant_wr;
  logic             grant_rd;
  logic             rd_busy;
  logic [LAT_W-1:0] rd_cnt;

  // Round-robin pick between the two ports; on a tie, the port not served last wins.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wr_req && rd_req) begin
      grant_wr = !prefer_rd;
      grant_rd = prefer_rd;
    end else begin
      grant_wr = wr_req;
      grant_rd = rd_req;
    end
  end

  // Init sequence, slot sequencing, arbitration and refresh timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      cnt         <= '0;
      slot_ref    <= 1'b0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      prefer_rd   <= 1'b0;
      init_done   <= 1'b0;
      sdr_cmd     <= CMD_NOP;
      sdr_addr    <= '0;
      sdr_datain  <= '0;
      sdr_dm      <= '0;
      wr_gnt      <= 1'b0;
      rd_gnt      <= 1'b0;
    end else begin
      // Commands and grants are single-cycle; address/data stay held.
      sdr_cmd <= CMD_NOP;
      wr_gnt  <= 1'b0;
      rd_gnt  <= 1'b0;

      case (state)
        S_WAIT: begin
          if (cnt == WAIT_END) begin
            state    <= S_PRE;
            cnt      <= '0;
            sdr_cmd  <= CMD_PRECHARGE;
            sdr_addr <= PRE_ALL_ADDR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PRE: begin
          if (cnt == REF_END) begin
            state    <= S_REF1;
            cnt      <= '0;
            sdr_cmd  <= CMD_REFRESH;
            sdr_addr <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REF1: begin
          if (cnt == REF_END) begin
            state    <= S_REF2;
            cnt      <= '0;
            sdr_cmd  <= CMD_REFRESH;
            sdr_addr <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REF2: begin
          if (cnt == REF_END) begin
            state    <= S_LMR;
            cnt      <= '0;
            sdr_cmd  <= CMD_LOAD_MODE;
            sdr_addr <= MODE_ADDR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LMR: begin
          if (cnt == CMD_END) begin
            state     <= S_IDLE;
            cnt       <= '0;
            init_done <= 1'b1;
            ref_cnt   <= REF_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_IDLE: begin
          cnt <= '0;
          if (ref_pending) begin
            state       <= S_SLOT;
            slot_ref    <= 1'b1;
            ref_pending <= 1'b0;
            sdr_cmd     <= CMD_REFRESH;
            sdr_addr    <= '0;
          end else if (grant_wr) begin
            state      <= S_SLOT;
            slot_ref   <= 1'b0;
            prefer_rd  <= 1'b1;
            sdr_cmd    <= CMD_WRITEA;
            sdr_addr   <= wr_addr;
            sdr_datain <= wr_data;
            sdr_dm     <= wr_dm;
            wr_gnt     <= 1'b1;
          end else if (grant_rd) begin
            state     <= S_SLOT;
            slot_ref  <= 1'b0;
            prefer_rd <= 1'b0;
            sdr_cmd   <= CMD_READA;
            sdr_addr  <= rd_addr;
            rd_gnt    <= 1'b1;
          end
        end

        S_SLOT: begin
          if (cnt == (slot_ref ? REF_END : CMD_END)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
      endcase

      // Refresh timer sits after the FSM so that a fresh expiry overrides the
      // clear from a refresh issued in the same cycle. The reload replaces the
      // zero the count would otherwise reach, giving exactly REF_PERIOD cycles.
      if (init_done) begin
        if (ref_cnt <= REF_W'(1)) begin
          ref_pending <= 1'b1;
          ref_cnt     <= REF_LOAD;
        end else begin
          ref_cnt <= ref_cnt - 1'b1;
        end
      end
    end
  end

  // Read return: capture controller data RD_LAT cycles after the READA cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_busy  <= 1'b0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      // rd_gnt is high during the READA cycle, so this edge is latency 1 and the count starts at 2.
      if (rd_gnt) begin
        rd_busy <= 1'b1;
        rd_cnt  <= LAT_W'(2);
      end else if (rd_busy) begin
        if (rd_cnt == LAT_END) begin
          rd_busy  <= 1'b0;
          rd_valid <= 1'b1;
          rd_data  <= sdr_dataout;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_scheduler.sv
// tb_sdram_scheduler: randomized scoreboard bench for sdram_scheduler.
// A transaction-level model predicts the command stream and read returns.
// The predictions go into queues, and a negedge monitor compares them with the DUT.
`timescale 1ns/1ps
module tb_sdram_scheduler;

  localparam int ASIZE      = 25;
  localparam int DSIZE      = 16;
  localparam int INIT_WAIT  = 16;
  localparam int REF_PERIOD = 100;
  localparam int CMD_SLOT   = 8;
  localparam int REF_SLOT   = 10;
  localparam int RD_LAT     = 6;
  localparam int NEVER      = 32'h3fff_ffff;

  localparam logic [2:0] C_NOP = 3'b000;
  localparam logic [2:0] C_RD  = 3'b001;
  localparam logic [2:0] C_WR  = 3'b010;
  localparam logic [2:0] C_REF = 3'b011;
  localparam logic [2:0] C_PRE = 3'b100;
  localparam logic [2:0] C_LMR = 3'b101;

  logic             clk = 1'b0;
  logic             reset;
  logic             init_done;
  logic             wr_req;
  logic [ASIZE-1:0] wr_addr;
  logic [DSIZE-1:0] wr_data;
  logic [1:0]       wr_dm;
  logic             wr_gnt;
  logic             rd_req;
  logic [ASIZE-1:0] rd_addr;
  logic             rd_gnt;
  logic [DSIZE-1:0] rd_data;
  logic             rd_valid;
  logic [2:0]       sdr_cmd;
  logic [ASIZE-1:0] sdr_addr;
  logic [DSIZE-1:0] sdr_datain;
  logic [1:0]       sdr_dm;
  logic [DSIZE-1:0] sdr_dataout;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  sdram_scheduler #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .INIT_WAIT(INIT_WAIT), .REF_PERIOD(REF_PERIOD),
    .CMD_SLOT(CMD_SLOT), .REF_SLOT(REF_SLOT), .RD_LAT(RD_LAT), .MODE_WORD(13'h020)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dm(wr_dm), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .sdr_cmd(sdr_cmd), .sdr_addr(sdr_addr), .sdr_datain(sdr_datain), .sdr_dm(sdr_dm),
    .sdr_dataout(sdr_dataout)
  );

  typedef struct {
    int               cyc;
    logic [2:0]       cmd;
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
    logic [1:0]       dm;
  } cmd_exp_t;

  typedef struct {
    int               cyc;
    logic [DSIZE-1:0] data;
  } rd_exp_t;

  cmd_exp_t         exp_cmd[$];
  rd_exp_t          exp_rd[$];
  logic [DSIZE-1:0] mem[int];

  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  bit  started     = 1'b0;
  int  done_cyc    = NEVER;
  int  free_at     = NEVER;
  int  next_exp    = NEVER;
  bit  ref_due     = 1'b0;
  bit  last_was_wr = 1'b0;

  cmd_exp_t         e;
  rd_exp_t          r;
  int               hold_end = -1;
  logic [ASIZE-1:0] hold_addr;
  bit               hold_wr;
  logic [DSIZE-1:0] hold_data;
  logic [1:0]       hold_dm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [DSIZE-1:0] mem_read(input logic [ASIZE-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {a[7:0], ~a[7:0]};
  endfunction

  task automatic mem_write(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d,
                           input logic [1:0] m);
    logic [DSIZE-1:0] v;
    v = mem_read(a);
    if (!m[0]) v[7:0] = d[7:0];
    if (!m[1]) v[15:8] = d[15:8];
    mem[int'(a)] = v;
  endtask

  task automatic push_cmd(input int c, input logic [2:0] cmd, input logic [ASIZE-1:0] a,
                          input logic [DSIZE-1:0] d, input logic [1:0] m);
    cmd_exp_t x;
    x.cyc = c; x.cmd = cmd; x.addr = a; x.data = d; x.dm = m;
    exp_cmd.push_back(x);
  endtask

  // Reference model: init schedule plus slot-based arbitration with periodic refresh.
  always @(posedge clk) begin
    if (reset) begin
      started     = 1'b1;
      cyc         = 0;
      exp_cmd.delete();
      exp_rd.delete();
      done_cyc    = NEVER;
      free_at     = NEVER;
      next_exp    = NEVER;
      ref_due     = 1'b0;
      last_was_wr = 1'b0;
    end else begin
      cyc++;
      if (cyc == 1) begin
        push_cmd(INIT_WAIT + 1,                C_PRE, 25'h400, '0, '0);
        push_cmd(INIT_WAIT + 1 + REF_SLOT,     C_REF, '0,      '0, '0);
        push_cmd(INIT_WAIT + 1 + 2 * REF_SLOT, C_REF, '0,      '0, '0);
        push_cmd(INIT_WAIT + 1 + 3 * REF_SLOT, C_LMR, 25'h20,  '0, '0);
        done_cyc = INIT_WAIT + 1 + 3 * REF_SLOT + CMD_SLOT;
        free_at  = done_cyc + 1;
        next_exp = done_cyc + REF_PERIOD;
      end
      if (cyc >= free_at) begin
        if (ref_due) begin
          push_cmd(cyc, C_REF, '0, '0, '0);
          ref_due = 1'b0;
          free_at = cyc + REF_SLOT + 1;
        end else if (wr_req && (!rd_req || !last_was_wr)) begin
          push_cmd(cyc, C_WR, wr_addr, wr_data, wr_dm);
          mem_write(wr_addr, wr_data, wr_dm);
          last_was_wr = 1'b1;
          free_at = cyc + CMD_SLOT + 1;
        end else if (rd_req) begin
          push_cmd(cyc, C_RD, rd_addr, '0, '0);
          r.cyc  = cyc + RD_LAT;
          r.data = mem_read(rd_addr);
          exp_rd.push_back(r);
          last_was_wr = 1'b0;
          free_at = cyc + CMD_SLOT + 1;
        end
      end
      if (cyc == next_exp) begin
        ref_due  = 1'b1;
        next_exp = next_exp + REF_PERIOD;
      end
    end
  end

  // Monitor: compare DUT outputs against the scoreboard queues on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      if (cyc <= 1) begin
        chk("rst_ctl",  {sdr_cmd, init_done, wr_gnt, rd_gnt, rd_valid}, 64'd0);
        chk("rst_addr", sdr_addr, 64'd0);
        chk("rst_data", {sdr_datain, rd_data}, 64'd0);
        chk("rst_dm",   sdr_dm, 64'd0);
        hold_end = -1;
      end else begin
        if (exp_cmd.size() > 0 && exp_cmd[0].cyc <= cyc) begin
          e = exp_cmd.pop_front();
          chk("cmd",      sdr_cmd, e.cmd);
          chk("cmd_addr", sdr_addr, e.addr);
          chk("grants",   {wr_gnt, rd_gnt}, {e.cmd == C_WR, e.cmd == C_RD});
          hold_addr = e.addr;
          hold_wr   = (e.cmd == C_WR);
          hold_data = e.data;
          hold_dm   = e.dm;
          hold_end  = cyc + (((e.cmd == C_REF) || (e.cmd == C_PRE)) ? REF_SLOT : CMD_SLOT) - 1;
        end else begin
          chk("nop", {sdr_cmd, wr_gnt, rd_gnt}, 64'd0);
        end
        if (cyc <= hold_end) begin
          chk("hold_addr", sdr_addr, hold_addr);
          if (hold_wr) chk("hold_wdata", {sdr_datain, sdr_dm}, {hold_data, hold_dm});
        end
        chk("init_done", init_done, cyc >= done_cyc);
        if (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
          r = exp_rd.pop_front();
          chk("rd_valid", rd_valid, 64'd1);
          chk("rd_data",  rd_data, r.data);
        end else begin
          chk("rd_valid_idle", rd_valid, 64'd0);
        end
      end
    end
  end

  // Controller read path: correct data only in the capture cycle, junk otherwise.
  initial begin
    sdr_dataout = '0;
    forever begin
      @(negedge clk);
      #1;
      if (exp_rd.size() > 0)
        sdr_dataout = (exp_rd[0].cyc == cyc + 1) ? exp_rd[0].data : ~exp_rd[0].data;
      else
        sdr_dataout = 16'($urandom);
    end
  end

  function automatic logic [ASIZE-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ASIZE'($urandom);
    return ASIZE'(32'h100 + $urandom_range(0, 15));
  endfunction

  task automatic wait_gnt(input bit is_wr, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_wr ? wr_gnt : rd_gnt) && n < budget);
    chk(is_wr ? "wr_gnt_wait" : "rd_gnt_wait", is_wr ? wr_gnt : rd_gnt, 64'd1);
    if (is_wr) wr_req = 1'b0;
    else       rd_req = 1'b0;
  endtask

  task automatic issue_write(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d,
                             input logic [1:0] m);
    wr_addr = a; wr_data = d; wr_dm = m; wr_req = 1'b1;
    wait_gnt(1'b1, 200);
  endtask

  task automatic issue_read(input logic [ASIZE-1:0] a);
    rd_addr = a; rd_req = 1'b1;
    wait_gnt(1'b0, 200);
  endtask

  task automatic random_traffic(input int n, input int p_req, input bit allow_drop);
    repeat (n) begin
      @(negedge clk);
      if (wr_gnt) wr_req = 1'b0;
      if (rd_gnt) rd_req = 1'b0;
      if (!wr_req) begin
        if ($urandom_range(0, 99) < p_req) begin
          wr_addr = rand_addr(); wr_data = 16'($urandom); wr_dm = 2'($urandom); wr_req = 1'b1;
        end
      end else if (allow_drop && $urandom_range(0, 299) == 0) begin
        wr_req = 1'b0;
      end
      if (!rd_req) begin
        if ($urandom_range(0, 99) < p_req) begin
          rd_addr = rand_addr(); rd_req = 1'b1;
        end
      end else if (allow_drop && $urandom_range(0, 299) == 0) begin
        rd_req = 1'b0;
      end
    end
  endtask

  // Stimulus sequence.
  initial begin
    int n;
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_dm = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // A write raised during init must wait for init_done.
    repeat (5) @(negedge clk);
    issue_write(25'h1ABCD, 16'h1234, 2'b01);

    mem[32'h10] = 16'hA5A5;
    issue_write(25'h12345, 16'hBEEF, 2'b00);
    issue_read(25'h00010);
    issue_read(25'h12345);
    issue_read(25'h1ABCD);

    random_traffic(2500, 30, 1'b1);
    random_traffic(600, 100, 1'b0);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (30) @(negedge clk);

    // Raise a read in the cycle the refresh request appears.
    n = 0;
    while (cyc != next_exp - REF_PERIOD && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("align_wait", n < 300, 64'd1);
    issue_read(25'h155);

    // Reset while a read is in flight.
    repeat (20) @(negedge clk);
    rd_addr = 25'h104; rd_req = 1'b1;
    wait_gnt(1'b0, 200);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (INIT_WAIT + 3 * REF_SLOT + CMD_SLOT + 5) @(negedge clk);
    random_traffic(400, 30, 1'b1);
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (40) @(negedge clk);
    #2;
    chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    chk("rd_queue_empty",  64'(exp_rd.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_scheduler.md
Name: sdram_scheduler

Overview:
- Sequences and shares the 16-bit SDRAM controller command interface (cmd/addr/datain/dm/dataout) between two requesters: a write port (pixel writer) and a read port (frame reader).
- Performs the SDRAM power-up init sequence and inserts periodic auto-refresh.
- Each access is a single word issued in a fixed-length time slot.
- Sits between ISP stream buffers and the SDRAM controller.

Parameters:
- ASIZE, 25, address width
- DSIZE, 16, data width
- INIT_WAIT, 20000, NOP cycles after reset before init commands
- REF_PERIOD, 1560, cycles between refresh requests
- CMD_SLOT, 8, cycles occupied by one read/write/load-mode slot (command cycle included)
- REF_SLOT, 10, cycles occupied by a precharge/refresh slot
- RD_LAT, 6, cycles from the READA command cycle to valid sdr_dataout; must be < CMD_SLOT
- MODE_WORD, 13'h020, value placed on sdr_addr[12:0] for LOAD_MODE

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- init_done  out  1  high once the init sequence has completed
- wr_req  in  1  write request; held with wr_addr/wr_data/wr_dm until wr_gnt
- wr_addr  in  ASIZE  write word address
- wr_data  in  DSIZE  write data
- wr_dm  in  DSIZE/8  write byte mask
- wr_gnt  out  1  one-cycle pulse: write command issued
- rd_req  in  1  read request; held with rd_addr until rd_gnt
- rd_addr  in  ASIZE  read word address
- rd_gnt  out  1  one-cycle pulse: read command issued
- rd_data  out  DSIZE  read data
- rd_valid  out  1  one-cycle pulse: rd_data valid
- sdr_cmd  out  3  controller command: 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH, 100 PRECHARGE, 101 LOAD_MODE
- sdr_addr  out  ASIZE  controller address
- sdr_datain  out  DSIZE  controller write data
- sdr_dm  out  DSIZE/8  controller byte mask
- sdr_dataout  in  DSIZE  controller read data

Behaviour:
- All outputs are registered. While reset is high and on the cycle after reset is released: sdr_cmd=NOP, sdr_addr=0, sdr_datain=0, sdr_dm=0, init_done=0, wr_gnt=rd_gnt=rd_valid=0, rd_data=0.
- FSM states: S_WAIT, S_PRE, S_REF1, S_REF2, S_LMR, S_IDLE, S_SLOT.
  - S_WAIT: count INIT_WAIT cycles, sdr_cmd=NOP.
  - S_PRE: drive one cycle PRECHARGE with sdr_addr[10]=1 and all other bits 0, then REF_SLOT-1 NOP cycles.
  - S_REF1, S_REF2: each drives one cycle REFRESH followed by REF_SLOT-1 NOP cycles.
  - S_LMR: drive one cycle LOAD_MODE with sdr_addr = zero-extended MODE_WORD, then CMD_SLOT-1 NOP cycles.
  - Leaving S_LMR: init_done becomes 1 (and stays 1 until reset), enter S_IDLE, refresh counter loaded with REF_PERIOD.
- Refresh timer: free-running down-counter, active only when init_done=1.
  - On reaching 0: set ref_pending and reload REF_PERIOD.
  - ref_pending clears on the cycle the REFRESH command is issued.
- S_IDLE arbitration, evaluated each cycle, fixed priority:
  - ref_pending first; otherwise wr_req vs rd_req by round-robin.
  - When both request, the port not granted last wins. The first tie after reset goes to the write port.
  - The winner's command appears on sdr_cmd on the next clock edge.
- Slot issue cycle:
  - WRITEA: sdr_addr=wr_addr, sdr_datain=wr_data, sdr_dm=wr_dm, wr_gnt=1.
  - READA: sdr_addr=rd_addr, rd_gnt=1.
  - REFRESH: sdr_addr=0.
  - Inputs are sampled in the S_IDLE decision cycle.
  - sdr_cmd returns to NOP the following cycle. sdr_addr, sdr_datain and sdr_dm are held for the whole slot.
- Slot length: CMD_SLOT cycles for read/write, REF_SLOT cycles for refresh, then back to S_IDLE. Back-to-back command spacing is therefore CMD_SLOT+1 or REF_SLOT+1 cycles.
- Read return: RD_LAT cycles after the READA command cycle, rd_data<=sdr_dataout and rd_valid=1 for exactly one cycle. At most one read is outstanding.
- Requests arriving before init_done=1 are not granted; they wait.
- A request that drops before its grant is not issued. No request is ever dropped while held.
- ref_pending set during a slot is serviced at the next S_IDLE decision, ahead of any waiting requests. If the counter expires again while ref_pending is still set, ref_pending stays 1 (no double refresh).
- Reset asserted mid-slot or mid-init: the next cycle shows NOP, any pending rd_valid is suppressed, the round-robin pointer resets to favour the write port, and the full init sequence restarts.

Test Plan:
- Params INIT_WAIT=16, REF_PERIOD=100, CMD_SLOT=8, REF_SLOT=10, RD_LAT=6, release reset -> 16 NOPs, then PRECHARGE with sdr_addr=25'h400, REFRESH 10 cycles later, REFRESH 10 cycles after that, LOAD_MODE with sdr_addr=25'h20 10 cycles after that; init_done=1 8 cycles after LOAD_MODE.
- After init, wr_req with wr_addr=25'h12345, wr_data=16'hBEEF, wr_dm=2'b00 -> next cycle sdr_cmd=010, wr_gnt=1, sdr_datain=BEEF held 8 cycles, sdr_cmd=NOP for 7 cycles.
- rd_req with rd_addr=25'h00010, model returns 16'hA5A5 on sdr_dataout 6 cycles after READA -> rd_valid pulses once with rd_data=A5A5; no other rd_valid.
- wr_req and rd_req held continuously -> commands alternate WRITEA, READA, WRITEA… starting with WRITEA, spaced 9 cycles apart; a REFRESH is inserted within one slot of every 100-cycle counter expiry.
- rd_req asserted in the same cycle ref_pending sets -> REFRESH issued first, READA 11 cycles later.
- Assert reset 3 cycles after a READA issue -> rd_valid never pulses, sdr_cmd=NOP, init_done=0, init sequence repeats exactly as in the first scenario.
